// File: rtl/acorn128_pkg.sv
// Shared types and constants for the ACORN-128 host controller and its helpers.
package acorn128_pkg;

  localparam int KEY_W           = 128;
  localparam int LEN_W           = 64;
  localparam int CORE_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CORE_RST = 3'd1,
    ST_RUN      = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/acorn128_tag_cmp.sv
// Constant-time 128-bit tag equality: XOR then OR-reduce, every bit always contributes.
module acorn128_tag_cmp
  import acorn128_pkg::*;
(
  input  logic [KEY_W-1:0] tag_a,
  input  logic [KEY_W-1:0] tag_b,
  output logic             equal
);

  logic [KEY_W-1:0] diff_s;

  // Fold all difference bits so the result never depends on where tags differ.
  always_comb begin
    diff_s = tag_a ^ tag_b;
    equal  = ~|diff_s;
  end

endmodule

// File: rtl/acorn128_host_ctrl.sv
// Host-side sequencer for an ACORN-128 core: latches a request, resets and runs
// the core, captures or times out its result, and holds a response until taken.
module acorn128_host_ctrl
  import acorn128_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic             req_encrypt_in,
  input  logic [KEY_W-1:0] req_key_in,
  input  logic [KEY_W-1:0] req_iv_in,
  input  logic [KEY_W-1:0] req_ad_in,
  input  logic [KEY_W-1:0] req_data_in,
  input  logic [KEY_W-1:0] req_tag_in,
  input  logic [LEN_W-1:0] req_len_in,
  output logic             core_rst_out,
  output logic             core_start_out,
  output logic             core_encrypt_out,
  output logic [KEY_W-1:0] core_key_out,
  output logic [KEY_W-1:0] core_iv_out,
  output logic [KEY_W-1:0] core_ad_out,
  output logic [KEY_W-1:0] core_plaintext_out,
  output logic [KEY_W-1:0] core_ciphertext_out,
  output logic [LEN_W-1:0] core_len_out,
  input  logic             core_ready_in,
  input  logic [KEY_W-1:0] core_ciphertext_in,
  input  logic [KEY_W-1:0] core_plaintext_in,
  input  logic [KEY_W-1:0] core_tag_in,
  output logic             resp_valid_out,
  input  logic             resp_ready_in,
  output logic [KEY_W-1:0] resp_data_out,
  output logic [KEY_W-1:0] resp_tag_out,
  output logic             resp_auth_ok_out,
  output logic             resp_timeout_out
);

  // One counter serves both the core-reset pulse and the RUN timeout.
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 4) ? $clog2(TIMEOUT_CYCLES) : 2;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(CORE_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [KEY_W-1:0] tag_r;
  logic             tag_ok_s;

  acorn128_tag_cmp u_tag_cmp (
    .tag_a (core_tag_in),
    .tag_b (tag_r),
    .equal (tag_ok_s)
  );

  // Sequencer state, latched request operands and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r             <= ST_IDLE;
      cnt_r               <= '0;
      tag_r               <= '0;
      req_ready_out       <= 1'b1;
      core_rst_out        <= 1'b1;
      core_start_out      <= 1'b0;
      core_encrypt_out    <= 1'b0;
      core_key_out        <= '0;
      core_iv_out         <= '0;
      core_ad_out         <= '0;
      core_plaintext_out  <= '0;
      core_ciphertext_out <= '0;
      core_len_out        <= '0;
      resp_valid_out      <= 1'b0;
      resp_data_out       <= '0;
      resp_tag_out        <= '0;
      resp_auth_ok_out    <= 1'b0;
      resp_timeout_out    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          core_rst_out <= 1'b0;
          if (req_valid_in) begin
            state_r             <= ST_CORE_RST;
            cnt_r               <= '0;
            req_ready_out       <= 1'b0;
            core_rst_out        <= 1'b1;
            core_encrypt_out    <= req_encrypt_in;
            core_key_out        <= req_key_in;
            core_iv_out         <= req_iv_in;
            core_ad_out         <= req_ad_in;
            core_len_out        <= req_len_in;
            tag_r               <= req_tag_in;
            core_plaintext_out  <= req_encrypt_in ? req_data_in : '0;
            core_ciphertext_out <= req_encrypt_in ? '0 : req_data_in;
          end
        end
        ST_CORE_RST: begin
          if (cnt_r == RST_LAST) begin
            state_r        <= ST_RUN;
            cnt_r          <= '0;
            core_rst_out   <= 1'b0;
            core_start_out <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RUN: begin
          // Ready in the first RUN cycle may be stale from before the core saw start.
          if ((cnt_r != '0) && core_ready_in) begin
            state_r        <= ST_CAPTURE;
            core_start_out <= 1'b0;
          end else if (cnt_r == RUN_LAST) begin
            state_r          <= ST_RESP;
            core_start_out   <= 1'b0;
            resp_valid_out   <= 1'b1;
            resp_timeout_out <= 1'b1;
            resp_data_out    <= '0;
            resp_tag_out     <= '0;
            resp_auth_ok_out <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          state_r          <= ST_RESP;
          resp_valid_out   <= 1'b1;
          resp_timeout_out <= 1'b0;
          resp_tag_out     <= core_tag_in;
          if (core_encrypt_out) begin
            resp_data_out    <= core_ciphertext_in;
            resp_auth_ok_out <= 1'b1;
          end else begin
            resp_data_out    <= tag_ok_s ? core_plaintext_in : '0;
            resp_auth_ok_out <= tag_ok_s;
          end
        end
        ST_RESP: begin
          if (resp_ready_in) begin
            state_r        <= ST_IDLE;
            resp_valid_out <= 1'b0;
            req_ready_out  <= 1'b1;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          req_ready_out  <= 1'b1;
          core_start_out <= 1'b0;
          resp_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/acorn128_host_ctrl.md
ACORN128_HOST_CTRL -- requirements
Module: acorn128_host_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 4096, max cycles waiting for core_ready_in before abort.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid_in  in  1  / req_ready_out  out  1: request handshake; transfer when both high on a rising edge.
REQ-005 req_encrypt_in  in  1  1 = encrypt, 0 = decrypt+verify.
REQ-006 req_key_in, req_iv_in, req_ad_in  in  128 each: key, IV, associated data.
REQ-007 req_data_in  in  128  plaintext (encrypt) or ciphertext (decrypt); req_tag_in  in  128  expected tag (decrypt only); req_len_in  in  64  data length in bits.
REQ-008 core_rst_out  out  1; core_start_out  out  1; core_encrypt_out  out  1: drive the ACORN-128 core controls.
REQ-009 core_key_out, core_iv_out, core_ad_out, core_plaintext_out, core_ciphertext_out  out  128; core_len_out  out  64: core operands.
REQ-010 core_ready_in  in  1; core_ciphertext_in, core_plaintext_in, core_tag_in  in  128: core results.
REQ-011 resp_valid_out  out  1  / resp_ready_in  in  1: response handshake.
REQ-012 resp_data_out  out  128; resp_tag_out  out  128; resp_auth_ok_out  out  1; resp_timeout_out  out  1.

Function
REQ-013 FSM states: IDLE, CORE_RST, RUN, CAPTURE, RESP.
REQ-014 IDLE: req_ready_out=1; on accept, latch all req_* into registers, go CORE_RST; req_ready_out=0 in every other state.
REQ-015 CORE_RST: core_rst_out=1 for exactly 2 cycles (CORE_RST_CYCLES), then RUN.
REQ-016 RUN: core_start_out=1 held level until leaving RUN; core_ready_in ignored in the first RUN cycle; core_ready_in=1 afterwards -> CAPTURE.
REQ-017 RUN: timeout counter increments each cycle; at count TIMEOUT_CYCLES-1 without ready -> RESP with resp_timeout_out=1, resp_data_out=0, resp_tag_out=0, resp_auth_ok_out=0.
REQ-018 Core operands driven continuously from latched registers; core_plaintext_out=latched data when encrypt else 0; core_ciphertext_out=latched data when decrypt else 0; core_encrypt_out=latched mode.
REQ-019 CAPTURE (1 cycle): encrypt -> data=core_ciphertext_in, tag=core_tag_in, auth_ok=1; decrypt -> tag=core_tag_in, auth_ok=(core_tag_in==latched tag, full 128 bits), data=core_plaintext_in if auth_ok else 128'h0.
REQ-020 Tag compare SHALL be constant-time (XOR, OR-reduce), no early exit.
REQ-021 RESP: resp_valid_out=1, outputs stable until resp_ready_in=1; on handshake -> IDLE; core_start_out=0 in RESP.
REQ-022 Latency: accept to core_start_out high = 3 cycles; core_ready_in to resp_valid_out = 2 cycles.
REQ-023 req_valid_in while busy: not accepted, no side effects; back-to-back request accepted in IDLE cycle after response handshake.
REQ-024 req_len_in passed unchanged; values other than 0..128 forwarded unchecked (core responsibility).

Reset
REQ-025 rst asserts: state=IDLE, counter=0, all latched registers=0 immediately (asynchronous).
REQ-026 Reset values: req_ready_out=1, core_rst_out=1, core_start_out=0, core_encrypt_out=0, all data outputs 0, resp_valid_out=0, resp_auth_ok_out=0, resp_timeout_out=0.
REQ-027 Reset mid-operation aborts without response; after release, next accepted request runs full sequence.

Structure
REQ-028 Shared package acorn128_pkg: state enum, KEY_W=128, LEN_W=64, CORE_RST_CYCLES=2.
REQ-029 One sub-module acorn128_tag_cmp (combinational constant-time 128-bit equality).

Verification
REQ-030 Encrypt key=EE..EE, iv=FF..FF, ad=FF..FF, data=66..66, len=128, with core -> resp_auth_ok_out=1, resp_data_out/resp_tag_out equal core ciphertext/tag.
REQ-031 Decrypt that ciphertext with that tag -> resp_auth_ok_out=1, resp_data_out=66..66.
REQ-032 Same decrypt, req_tag_in bit 0 flipped -> resp_auth_ok_out=0, resp_data_out=0, resp_tag_out=true tag.
REQ-033 Stub core never raises ready, TIMEOUT_CYCLES=16 -> resp_timeout_out=1 exactly 16 RUN cycles after start.
REQ-034 resp_ready_in held low 10 cycles -> resp outputs stable; req_valid_in high throughout not accepted until cycle after handshake.
REQ-035 rst pulsed in RUN -> outputs at reset values same cycle; no resp_valid_out; next request completes normally.
